// File: rtl/register_wb_buf.sv
// Write-back stage: decodes one op per cycle into up to two register writes,
// queues them in a DEPTH-entry FIFO, and forwards the youngest queued value.
module register_wb_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            r1,
    input  logic [DATA_W-1:0]            r2,
    input  logic [ADDR_W-1:0]            a1,
    input  logic [ADDR_W-1:0]            a2,
    input  logic [3:0]                   op,
    input  logic                         proceed,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            wr1,
    output logic [DATA_W-1:0]            wr2,
    output logic [ADDR_W-1:0]            wa1,
    output logic [ADDR_W-1:0]            wa2,
    output logic [1:0]                   write,
    input  logic                         wr_ack,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    input  logic [ADDR_W-1:0]            rq_addr,
    output logic                         rq_hit,
    output logic [DATA_W-1:0]            rq_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] q_wr1 [DEPTH];
    logic [DATA_W-1:0] q_wr2 [DEPTH];
    logic [ADDR_W-1:0] q_wa1 [DEPTH];
    logic [ADDR_W-1:0] q_wa2 [DEPTH];
    logic [1:0]        q_wen [DEPTH];

    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] d_wr1, d_wr2;
    logic [ADDR_W-1:0] d_wa1, d_wa2;
    logic [1:0]        d_wen;
    logic              enq, deq, empty;

    always_comb begin
        d_wr1 = '0;
        d_wr2 = '0;
        d_wa1 = '0;
        d_wa2 = '0;
        d_wen = 2'b00;
        case (op)
            4'd1: begin d_wr1 = r1; d_wa1 = a1;                d_wen = 2'b01; end
            4'd2: begin d_wr1 = r1; d_wa1 = a2;                d_wen = 2'b01; end
            4'd3: begin d_wr1 = r1; d_wa1 = r2[ADDR_W-1:0];    d_wen = 2'b01; end
            4'd4: begin d_wr1 = r2; d_wa1 = a1;                d_wen = 2'b01; end
            4'd5: begin d_wr1 = r2; d_wa1 = a2;                d_wen = 2'b01; end
            4'd6: begin d_wr1 = r2; d_wa1 = r1[ADDR_W-1:0];    d_wen = 2'b01; end
            4'd7, 4'd8: begin
                // Same-address dual write collapses to the r2 write alone
                if (a1 == a2) begin
                    d_wr1 = r2;
                    d_wa1 = a1;
                    d_wen = 2'b01;
                end else if (op == 4'd7) begin
                    d_wr1 = r1; d_wa1 = a1;
                    d_wr2 = r2; d_wa2 = a2;
                    d_wen = 2'b11;
                end else begin
                    d_wr1 = r1; d_wa1 = a2;
                    d_wr2 = r2; d_wa2 = a1;
                    d_wen = 2'b11;
                end
            end
            default: d_wen = 2'b00;
        endcase
    end

    assign empty    = (count == '0);
    assign in_ready = (count != FULL_CNT);
    assign pending  = count;
    assign enq      = proceed && in_ready && (d_wen != 2'b00);
    assign deq      = wr_ack && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_wr1[i] <= '0;
                q_wr2[i] <= '0;
                q_wa1[i] <= '0;
                q_wa2[i] <= '0;
                q_wen[i] <= '0;
            end
        end else begin
            if (enq) begin
                q_wr1[wptr] <= d_wr1;
                q_wr2[wptr] <= d_wr2;
                q_wa1[wptr] <= d_wa1;
                q_wa2[wptr] <= d_wa2;
                q_wen[wptr] <= d_wen;
                wptr        <= wptr + 1'b1;
            end
            if (deq)
                rptr <= rptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        write = empty ? 2'b00 : q_wen[rptr];
        wr1   = empty ? '0    : q_wr1[rptr];
        wr2   = empty ? '0    : q_wr2[rptr];
        wa1   = empty ? '0    : q_wa1[rptr];
        wa2   = empty ? '0    : q_wa2[rptr];
    end

    // Walk oldest to youngest so later matches win; port 2 overrides port 1
    logic [PTR_W-1:0] fw_slot;
    always_comb begin
        rq_hit  = 1'b0;
        rq_data = '0;
        fw_slot = rptr;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fw_slot = rptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (q_wen[fw_slot][0] && q_wa1[fw_slot] == rq_addr) begin
                    rq_hit  = 1'b1;
                    rq_data = q_wr1[fw_slot];
                end
                if (q_wen[fw_slot][1] && q_wa2[fw_slot] == rq_addr) begin
                    rq_hit  = 1'b1;
                    rq_data = q_wr2[fw_slot];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_wb_buf.sv
// Scoreboard bench for register_wb_buf: expected queue entries are pushed on
// accepted ops and compared against the head outputs until acknowledged.
module tb_register_wb_buf;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] wr1;
        logic [ADDR_W-1:0] wa1;
        logic [DATA_W-1:0] wr2;
        logic [ADDR_W-1:0] wa2;
        logic [1:0]        write;
    } entry_t;

    logic              clk, rst;
    logic [DATA_W-1:0] r1, r2;
    logic [ADDR_W-1:0] a1, a2, rq_addr;
    logic [3:0]        op;
    logic              proceed, in_ready, wr_ack, rq_hit;
    logic [DATA_W-1:0] wr1, wr2, rq_data;
    logic [ADDR_W-1:0] wa1, wa2;
    logic [1:0]        write;
    logic [$clog2(DEPTH+1)-1:0] pending;

    int checks   = 0;
    int failures = 0;
    entry_t sb[$];

    register_wb_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .r1(r1), .r2(r2), .a1(a1), .a2(a2), .op(op),
        .proceed(proceed), .in_ready(in_ready), .wr1(wr1), .wr2(wr2),
        .wa1(wa1), .wa2(wa2), .write(write), .wr_ack(wr_ack),
        .pending(pending), .rq_addr(rq_addr), .rq_hit(rq_hit), .rq_data(rq_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic entry_t decode(input logic [3:0] o, input logic [DATA_W-1:0] v1,
                                      input logic [DATA_W-1:0] v2, input logic [ADDR_W-1:0] x1,
                                      input logic [ADDR_W-1:0] x2);
        entry_t e = '0;
        if (o >= 4'd1 && o <= 4'd6) begin
            e.write = 2'b01;
            e.wr1   = (o <= 4'd3) ? v1 : v2;
            case (o)
                4'd1, 4'd4: e.wa1 = x1;
                4'd2, 4'd5: e.wa1 = x2;
                4'd3:       e.wa1 = v2[ADDR_W-1:0];
                default:    e.wa1 = v1[ADDR_W-1:0];
            endcase
        end else if (o == 4'd7 || o == 4'd8) begin
            if (x1 == x2) begin
                e.write = 2'b01; e.wr1 = v2; e.wa1 = x1;
            end else begin
                e.write = 2'b11; e.wr1 = v1; e.wr2 = v2;
                e.wa1 = (o == 4'd7) ? x1 : x2;
                e.wa2 = (o == 4'd7) ? x2 : x1;
            end
        end
        return e;
    endfunction

    task automatic check_state();
        entry_t h;
        logic hit;
        logic [DATA_W-1:0] data;
        h = (sb.size() == 0) ? entry_t'('0) : sb[0];
        check("write", write, h.write);
        check("wr1", wr1, h.wr1);
        check("wa1", wa1, h.wa1);
        check("wr2", wr2, h.wr2);
        check("wa2", wa2, h.wa2);
        check("pending", pending, sb.size());
        check("in_ready", in_ready, sb.size() < DEPTH);
        hit = 1'b0;
        data = '0;
        for (int i = sb.size() - 1; i >= 0 && !hit; i--) begin
            if (sb[i].write[1] && sb[i].wa2 == rq_addr) begin
                hit = 1'b1; data = sb[i].wr2;
            end else if (sb[i].write[0] && sb[i].wa1 == rq_addr) begin
                hit = 1'b1; data = sb[i].wr1;
            end
        end
        check("rq_hit", rq_hit, hit);
        check("rq_data", rq_data, data);
    endtask

    task automatic cycle();
        entry_t d;
        bit enq, deq;
        check_state();
        d   = decode(op, r1, r2, a1, a2);
        enq = proceed && (sb.size() < DEPTH) && (d.write != 2'b00);
        deq = wr_ack && (sb.size() != 0);
        @(posedge clk);
        if (deq) void'(sb.pop_front());
        if (enq) sb.push_back(d);
        #1;
    endtask

    initial begin
        rst = 1'b0; op = '0; r1 = '0; r2 = '0; a1 = '0; a2 = '0;
        proceed = 1'b0; wr_ack = 1'b0; rq_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_write", write, 2'b00);
        check("rst_pending", pending, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_rq_hit", rq_hit, 0);
        rst = 1'b1;
        cycle();

        // single write, held for 5 cycles then acknowledged
        op = 4'd1; r1 = 32'hDEADBEEF; a1 = 5'd3; proceed = 1'b1;
        cycle();
        proceed = 1'b0;
        check("t1_wr1", wr1, 32'hDEADBEEF);
        check("t1_wa1", wa1, 3);
        check("t1_pending", pending, 1);
        repeat (5) cycle();
        wr_ack = 1'b1;
        cycle();
        wr_ack = 1'b0;
        check("t1_empty_write", write, 2'b00);
        check("t1_empty_pending", pending, 0);

        // dual write: collision then distinct addresses
        op = 4'd7; r1 = 32'h11; r2 = 32'h22; a1 = 5'd9; a2 = 5'd9; proceed = 1'b1;
        cycle();
        a1 = 5'd4; a2 = 5'd5;
        cycle();
        proceed = 1'b0;
        check("coll_write", write, 2'b01);
        check("coll_wr1", wr1, 32'h22);
        check("coll_wa1", wa1, 9);
        wr_ack = 1'b1;
        cycle();
        check("dual_write", write, 2'b11);
        check("dual_wr1", wr1, 32'h11);
        check("dual_wa2", wa2, 5);
        cycle();
        wr_ack = 1'b0;

        // fill, drop fifth, then drain with proceed held across wrap
        op = 4'd4; proceed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r2 = 32'h100 + i; a1 = ADDR_W'(i + 1);
            cycle();
        end
        check("full_in_ready", in_ready, 0);
        r2 = 32'h104; a1 = 5'd20;
        cycle();
        check("full_pending", pending, 4);
        wr_ack = 1'b1;
        repeat (6) cycle();
        proceed = 1'b0;
        repeat (4) cycle();
        wr_ack = 1'b0;

        // forwarding picks the youngest
        op = 4'd1; r1 = 32'hA; a1 = 5'd7; proceed = 1'b1;
        cycle();
        r1 = 32'hB;
        cycle();
        proceed = 1'b0;
        rq_addr = 5'd7; #1;
        check("fwd_hit", rq_hit, 1);
        check("fwd_data", rq_data, 32'hB);
        rq_addr = 5'd8; #1;
        check("fwd_miss_hit", rq_hit, 0);
        check("fwd_miss_data", rq_data, 0);
        wr_ack = 1'b1;
        repeat (2) cycle();
        wr_ack = 1'b0;

        // address from low bits of r2, then an undefined op
        op = 4'd3; r1 = 32'h33; r2 = 32'hFFFFFFE6; proceed = 1'b1;
        cycle();
        check("op3_wa1", wa1, 6);
        op = 4'd12;
        cycle();
        check("op12_pending", pending, 1);
        proceed = 1'b0;
        wr_ack = 1'b1;
        cycle();
        wr_ack = 1'b0;

        // asynchronous reset with three queued entries
        op = 4'd5; proceed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r2 = 32'h200 + i; a2 = ADDR_W'(i + 10);
            cycle();
        end
        proceed = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_write", write, 2'b00);
        check("arst_wr1", wr1, 0);
        check("arst_pending", pending, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_rq_hit", rq_hit, 0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        op = 4'd2; r1 = 32'h55; a2 = 5'd12; proceed = 1'b1;
        cycle();
        proceed = 1'b0;
        check("post_rst_write", write, 2'b01);
        check("post_rst_wr1", wr1, 32'h55);
        check("post_rst_wa1", wa1, 12);

        // random mix against the scoreboard
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            r1 = $urandom; r2 = $urandom;
            a1 = ADDR_W'($urandom_range(0, 7));
            a2 = ADDR_W'($urandom_range(0, 7));
            proceed = 1'($urandom_range(0, 1));
            wr_ack = ($urandom_range(0, 2) == 0);
            rq_addr = ADDR_W'($urandom_range(0, 7));
            #1;
            cycle();
        end
        proceed = 1'b0;
        wr_ack = 1'b1;
        repeat (DEPTH + 1) cycle();
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
